// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared constants and types for the FIFO read-side stream engine
package fifo_rd_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_WIDTH = 8;
  localparam int STAT_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } rd_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - circular output buffer absorbing FIFO read latency
module fifo_rd_skid import fifo_rd_pkg::*; #(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = 2,
  localparam int OW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [OW-1:0]    occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // a full buffer still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop && (occ_q != '0);
  assign do_push = push && ((occ_q != OW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
      occ_d = occ_q + OW'(do_push) - OW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign occ  = occ_q;
  assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO drain engine to valid/ready stream; FIFO_RD_STREAM_STATS_EN adds counters
module fifo_rd_stream import fifo_rd_pkg::*; #(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_data_out,
  input  logic              fifo_underflow,
  output logic              fifo_read_enable,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic              busy,
  output logic              err_underflow
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int CW = $clog2(BUF_DEPTH + RD_LAT + 1) + 1;

  rd_state_e        state_q, state_d;
  logic [RD_LAT-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;
  logic [OW-1:0]    occ;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    pending;
  logic             pop, issue;

  assign m_valid = (occ != '0) && (state_q != FLUSH);
  assign m_data  = head;
  assign pop     = m_valid && m_ready && !flush;

  // words already owed to the buffer, crediting this cycle's pop
  always_comb begin
    pending = CW'(occ) - CW'(pop);
    for (int i = 0; i < RD_LAT; i++) pending = pending + CW'(inflight_q[i]);
  end

  assign issue = en && !fifo_empty && !flush && !rst && (state_q != FLUSH)
              && (pending < CW'(BUF_DEPTH));
  assign fifo_read_enable = issue;

  always_comb begin
    inflight_d    = '0;
    inflight_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) inflight_d[i] = inflight_q[i-1];
  end

  fifo_rd_skid #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q[RD_LAT-1]),
    .push_data (fifo_data_out),
    .pop       (pop),
    .clear     (flush || (state_q == FLUSH)),
    .occ       (occ),
    .head      (head)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (issue) state_d = ACTIVE;
      ACTIVE:  if ((occ == '0) && (inflight_q == '0) && !issue) state_d = IDLE;
      FLUSH:   if (inflight_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = FLUSH;
  end

  assign err_d = err_q || fifo_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign err_underflow = err_q;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STAT_W-1:0] words_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
      stall_q <= '0;
    end else if (flush) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop) words_q <= sat_inc(words_q);
      if (m_valid && !m_ready) stall_q <= sat_inc(stall_q);
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed bench: DUT A (RD_LAT=1, 2-entry buffer), DUT B (RD_LAT=2, 3-entry buffer)
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // shared FIFO load controls
  int         ld_cnt = 0;
  logic [7:0] ld_val = 8'h00;

  // DUT A
  logic       enA = 1'b0, flA = 1'b0, mrA = 1'b0, ufA = 1'b0, ldA = 1'b0;
  logic       rdA, mvA, busyA, errA, emptyA;
  logic [7:0] mdA, doutA = 8'h00, nxtA = 8'h00;
  int         cntA = 0, rdsA = 0;
  logic [7:0] gotA [$];

  // DUT B
  logic       enB = 1'b0, flB = 1'b0, mrB = 1'b0, ufB = 1'b0, ldB = 1'b0;
  logic       rdB, mvB, busyB, errB, emptyB;
  logic [7:0] mdB, doutB = 8'h00, stgB = 8'h00, nxtB = 8'h00;
  int         cntB = 0, rdsB = 0;
  logic [7:0] gotB [$];

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] swA, ssA, swB, ssB;
`endif

  assign emptyA = (cntA == 0);
  assign emptyB = (cntB == 0);

  fifo_rd_stream #(.WIDTH(8), .RD_LAT(1), .BUF_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .en(enA), .flush(flA), .fifo_empty(emptyA),
    .fifo_data_out(doutA), .fifo_underflow(ufA), .fifo_read_enable(rdA),
    .m_valid(mvA), .m_ready(mrA), .m_data(mdA), .busy(busyA), .err_underflow(errA)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .stat_words(swA), .stat_stall(ssA)
`endif
  );

  fifo_rd_stream #(.WIDTH(8), .RD_LAT(2), .BUF_DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .en(enB), .flush(flB), .fifo_empty(emptyB),
    .fifo_data_out(doutB), .fifo_underflow(ufB), .fifo_read_enable(rdB),
    .m_valid(mvB), .m_ready(mrB), .m_data(mdB), .busy(busyB), .err_underflow(errB)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .stat_words(swB), .stat_stall(ssB)
`endif
  );

  // FIFO models: sequential words nxt, nxt+1, ...; data RD_LAT cycles after the read edge
  always @(posedge clk) begin
    if (ldA) begin
      cntA <= ld_cnt;
      nxtA <= ld_val;
    end else if (rdA && cntA != 0) begin
      doutA <= nxtA;
      nxtA  <= nxtA + 8'd1;
      cntA  <= cntA - 1;
    end
    if (rdA) rdsA <= rdsA + 1;
    if (mvA && mrA && !flA) gotA.push_back(mdA);
  end

  always @(posedge clk) begin
    if (ldB) begin
      cntB <= ld_cnt;
      nxtB <= ld_val;
    end else if (rdB && cntB != 0) begin
      stgB <= nxtB;
      nxtB <= nxtB + 8'd1;
      cntB <= cntB - 1;
    end
    doutB <= stgB;
    if (rdB) rdsB <= rdsB + 1;
    if (mvB && mrB && !flB) gotB.push_back(mdB);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({rdA, mvA, busyA, errA, mdA} !== 12'h000) begin
      fails++;
      $display("FAIL reset_a: got rd/mv/busy/err/data=%b%b%b%b/%0h want all 0", rdA, mvA, busyA, errA, mdA);
    end
    checks++;
    if ({rdB, mvB, busyB, errB, mdB} !== 12'h000) begin
      fails++;
      $display("FAIL reset_b: got rd/mv/busy/err/data=%b%b%b%b/%0h want all 0", rdB, mvB, busyB, errB, mdB);
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_steady();
    int base;
    base = gotA.size();
    mrA = 1'b1;
    enA = 1'b1;
    ld_cnt = 8; ld_val = 8'h10; ldA = 1'b1;
    tick();
    ldA = 1'b0;
    checks++;
    if (rdA !== 1'b1) begin fails++; $display("FAIL steady_issue: rd=%b want 1", rdA); end
    tick();
    checks++;
    if (mvA !== 1'b0) begin fails++; $display("FAIL steady_lat_early: m_valid=%b want 0", mvA); end
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mvA !== 1'b1 || mdA !== 8'(8'h10 + i)) begin
        fails++;
        $display("FAIL steady_beat%0d: valid=%b data=%0h want 1/%0h", i, mvA, mdA, 8'(8'h10 + i));
      end
      tick();
    end
    checks++;
    if (mvA !== 1'b0) begin fails++; $display("FAIL steady_tail: m_valid=%b want 0", mvA); end
    tick();
    checks++;
    if (busyA !== 1'b0) begin fails++; $display("FAIL steady_idle: busy=%b want 0", busyA); end
    checks++;
    if (gotA.size() != base + 8) begin
      fails++; $display("FAIL steady_count: beats=%0d want 8", gotA.size() - base);
    end
  endtask

  task automatic test_backpressure();
    int base, r0, k;
    base = gotA.size();
    r0 = rdsA;
    mrA = 1'b0;
    ld_cnt = 8; ld_val = 8'h20; ldA = 1'b1;
    tick();
    ldA = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (mvA) begin
        checks++;
        if (mdA !== 8'h20) begin fails++; $display("FAIL bp_hold: data=%0h want 20", mdA); end
      end
    end
    checks++;
    if (rdsA - r0 != 2) begin fails++; $display("FAIL bp_reads: reads=%0d want 2", rdsA - r0); end
    checks++;
    if (mvA !== 1'b1 || rdA !== 1'b0) begin
      fails++; $display("FAIL bp_state: valid=%b rd=%b want 1/0", mvA, rdA);
    end
    mrA = 1'b1;
    k = 0;
    while (gotA.size() < base + 8 && k < 40) begin tick(); k++; end
    checks++;
    if (gotA.size() < base + 8) begin
      fails++; $display("FAIL bp_drain: beats=%0d want 8", gotA.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (gotA[base+i] !== 8'(8'h20 + i)) begin
          fails++; $display("FAIL bp_order%0d: data=%0h want %0h", i, gotA[base+i], 8'(8'h20 + i));
        end
      end
    end
    tick(); tick();
  endtask

  task automatic test_empty_boundary();
    int base, r0;
    base = gotA.size();
    r0 = rdsA;
    ld_cnt = 1; ld_val = 8'h30; ldA = 1'b1;
    tick();
    ldA = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (rdsA - r0 != 1 || rdA !== 1'b0) begin
      fails++; $display("FAIL empty_reads: reads=%0d rd=%b want 1/0", rdsA - r0, rdA);
    end
    checks++;
    if (gotA.size() != base + 1 || gotA[gotA.size()-1] !== 8'h30) begin
      fails++; $display("FAIL empty_word: beats=%0d want one word 30", gotA.size() - base);
    end
    checks++;
    if (errA !== 1'b0 || busyA !== 1'b0) begin
      fails++; $display("FAIL empty_flags: err=%b busy=%b want 0/0", errA, busyA);
    end
  endtask

  task automatic test_underflow();
    ufA = 1'b1;
    tick();
    ufA = 1'b0;
    checks++;
    if (errA !== 1'b1) begin fails++; $display("FAIL uf_set: err=%b want 1", errA); end
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (errA !== 1'b1) begin fails++; $display("FAIL uf_sticky: err=%b want 1", errA); end
  endtask

  task automatic test_flush();
    int base, r0, k;
    base = gotB.size();
    r0 = rdsB;
    enB = 1'b1;
    mrB = 1'b0;
    ld_cnt = 8; ld_val = 8'h40; ldB = 1'b1;
    tick();
    ldB = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (mvB !== 1'b1 || mdB !== 8'h40 || rdsB - r0 != 3) begin
      fails++; $display("FAIL flush_pre: valid=%b data=%0h reads=%0d want 1/40/3", mvB, mdB, rdsB - r0);
    end
    flB = 1'b1;
    tick();
    flB = 1'b0;
    checks++;
    if (mvB !== 1'b0 || busyB !== 1'b1) begin
      fails++; $display("FAIL flush_drop: valid=%b busy=%b want 0/1", mvB, busyB);
    end
    tick();
    checks++;
    if (busyB !== 1'b0 || rdsB - r0 != 3) begin
      fails++; $display("FAIL flush_idle: busy=%b reads=%0d want 0/3", busyB, rdsB - r0);
    end
    mrB = 1'b1;
    k = 0;
    while (gotB.size() < base + 5 && k < 40) begin tick(); k++; end
    checks++;
    if (gotB.size() < base + 5) begin
      fails++; $display("FAIL flush_resume: beats=%0d want 5", gotB.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (gotB[base+i] !== 8'(8'h43 + i)) begin
          fails++; $display("FAIL flush_order%0d: data=%0h want %0h", i, gotB[base+i], 8'(8'h43 + i));
        end
      end
    end
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_async_reset();
    int base, k;
    base = gotB.size();
    mrB = 1'b1;
    enB = 1'b1;
    ld_cnt = 8; ld_val = 8'h50; ldB = 1'b1;
    tick();
    ldB = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rdB, mvB, busyB, errB, mdB} !== 12'h000) begin
      fails++;
      $display("FAIL areset_b: rd/mv/busy/err/data=%b%b%b%b/%0h want all 0", rdB, mvB, busyB, errB, mdB);
    end
    checks++;
    if (errA !== 1'b0) begin fails++; $display("FAIL areset_err: err=%b want 0", errA); end
    tick();
    #2 rst = 1'b0;
    k = 0;
    while (gotB.size() < base + 5 && k < 40) begin tick(); k++; end
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (gotB.size() != base + 5) begin
      fails++; $display("FAIL areset_resume: beats=%0d want 5", gotB.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (gotB[base+i] !== 8'(8'h53 + i)) begin
          fails++; $display("FAIL areset_order%0d: data=%0h want %0h", i, gotB[base+i], 8'(8'h53 + i));
        end
      end
    end
    checks++;
    if (busyB !== 1'b0) begin fails++; $display("FAIL areset_idle: busy=%b want 0", busyB); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_backpressure();
    test_empty_boundary();
    test_underflow();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
